// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared types and IO address map for the LC-3 memory controller.
// Revision    : 1.0
// ============================================================================
package lc3_pkg;

    typedef logic [15:0] word_t;

    localparam word_t c_kbsr_addr = 16'hFE00;
    localparam word_t c_kbdr_addr = 16'hFE02;
    localparam word_t c_dsr_addr  = 16'hFE04;
    localparam word_t c_ddr_addr  = 16'hFE06;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IO_KBSR = 2'd0,
        IO_KBDR = 2'd1,
        IO_DSR  = 2'd2,
        IO_DDR  = 2'd3
    } io_reg_t;

endpackage
`default_nettype wire

// File: rtl/lc3_io_regs.sv
`default_nettype none
// ============================================================================
// Module      : lc3_io_regs
// Description : Memory-mapped keyboard/display registers (KBSR/KBDR/DSR/DDR).
// Revision    : 1.0
// ============================================================================
module lc3_io_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_acc,
    input  logic        i_wr,
    input  io_reg_t     i_sel,
    input  word_t       i_wdata,
    output word_t       o_rdata,
    input  logic [7:0]  i_kb_data,
    input  logic        i_kb_strobe,
    output logic [7:0]  o_disp_data,
    output logic        o_disp_valid,
    input  logic        i_disp_ack
);

    logic       r_kb_rdy;
    logic       r_ie;
    logic [7:0] r_kbdr;
    logic       r_dsr_rdy;
    word_t      r_ddr;
    logic       r_disp_valid;

    logic       w_kbdr_rd;
    logic       w_kbsr_wr;
    logic       w_ddr_wr;

    always_comb begin
        w_kbdr_rd = i_acc && !i_wr && (i_sel == IO_KBDR);
        w_kbsr_wr = i_acc &&  i_wr && (i_sel == IO_KBSR);
        w_ddr_wr  = i_acc &&  i_wr && (i_sel == IO_DDR);
    end

    always_comb begin
        o_rdata = '0;
        case (i_sel)
            IO_KBSR: o_rdata = {r_kb_rdy, r_ie, 14'b0};
            IO_KBDR: o_rdata = {8'b0, r_kbdr};
            IO_DSR:  o_rdata = {r_dsr_rdy, 15'b0};
            IO_DDR:  o_rdata = r_ddr;
            default: o_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kb_rdy     <= 1'b0;
            r_ie         <= 1'b0;
            r_kbdr       <= '0;
            r_dsr_rdy    <= 1'b1;
            r_ddr        <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            // A new keystroke beats a simultaneous KBDR read.
            if (i_kb_strobe) begin
                r_kbdr   <= i_kb_data;
                r_kb_rdy <= 1'b1;
            end else if (w_kbdr_rd) begin
                r_kb_rdy <= 1'b0;
            end

            if (w_kbsr_wr) begin
                r_ie <= i_wdata[14];
            end

            if (w_ddr_wr) begin
                r_ddr        <= i_wdata;
                r_dsr_rdy    <= 1'b0;
                r_disp_valid <= 1'b1;
            end else if (i_disp_ack && r_disp_valid) begin
                r_disp_valid <= 1'b0;
                r_dsr_rdy    <= 1'b1;
            end
        end
    end

    assign o_disp_data  = r_ddr[7:0];
    assign o_disp_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_ctrl
// Description : LC-3 MAR/MDR owner, IO decode and RAM handshake sequencer.
// Revision    : 1.0
// ============================================================================
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int    WAIT_MAX  = 15,
    parameter word_t KBSR_ADDR = c_kbsr_addr,
    parameter word_t KBDR_ADDR = c_kbdr_addr,
    parameter word_t DSR_ADDR  = c_dsr_addr,
    parameter word_t DDR_ADDR  = c_ddr_addr
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_bus,
    input  logic        i_ld_mar,
    input  logic        i_ld_mdr,
    input  logic        i_mio_en,
    input  logic        i_r_w,
    output logic [15:0] o_mdr,
    output logic        o_rdy,
    output logic        o_bus_err,
    output logic        o_mem_en,
    output logic        o_mem_rw,
    output logic [15:0] o_mem_a,
    output logic [15:0] o_mem_din,
    input  logic [15:0] i_mem_dout,
    input  logic        i_mem_r,
    input  logic [7:0]  i_kb_data,
    input  logic        i_kb_strobe,
    output logic [7:0]  o_disp_data,
    output logic        o_disp_valid,
    input  logic        i_disp_ack
);

    localparam int                 CNT_W      = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]   C_WAIT_MAX = CNT_W'(WAIT_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    word_t              r_mar;
    word_t              r_mdr;
    logic               r_rdy;
    logic               r_bus_err;
    logic               r_mem_en;
    logic               r_mem_rw;
    logic               r_wr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_is_io;
    io_reg_t            w_io_sel;
    word_t              w_io_rdata;
    logic               w_io_acc;
    logic               w_mem_req;
    logic               w_mem_done;
    logic               w_timeout;

    always_comb begin
        w_is_io  = 1'b1;
        w_io_sel = IO_KBSR;
        if (r_mar == KBSR_ADDR) begin
            w_io_sel = IO_KBSR;
        end else if (r_mar == KBDR_ADDR) begin
            w_io_sel = IO_KBDR;
        end else if (r_mar == DSR_ADDR) begin
            w_io_sel = IO_DSR;
        end else if (r_mar == DDR_ADDR) begin
            w_io_sel = IO_DDR;
        end else begin
            w_is_io = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_io_acc    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mio_en) begin
                    if (w_is_io) begin
                        w_io_acc    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_mem_req   = 1'b1;
                        w_state_nxt = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (i_mem_r) begin
                    w_mem_done  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == C_WAIT_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            // Hold here until control drops mio_en so one request yields one access.
            ST_DONE: begin
                if (!i_mio_en) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_rdy     <= 1'b0;
            r_bus_err <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_rw  <= 1'b0;
            r_wr      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy    <= w_io_acc || w_mem_done || w_timeout;
            r_mem_en <= w_mem_req;
            r_mem_rw <= w_mem_req && i_r_w;

            if (w_mem_req) begin
                r_cnt <= '0;
                r_wr  <= i_r_w;
            end else if (r_state == ST_MEM) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end

            if (i_ld_mar) begin
                r_mar <= i_bus;
            end

            if (i_ld_mdr && !i_mio_en) begin
                r_mdr <= i_bus;
            end else if (w_io_acc && !i_r_w) begin
                r_mdr <= w_io_rdata;
            end else if (w_mem_done && !r_wr) begin
                r_mdr <= i_mem_dout;
            end
        end
    end

    lc3_io_regs u_io_regs (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_acc        (w_io_acc),
        .i_wr         (i_r_w),
        .i_sel        (w_io_sel),
        .i_wdata      (r_mdr),
        .o_rdata      (w_io_rdata),
        .i_kb_data    (i_kb_data),
        .i_kb_strobe  (i_kb_strobe),
        .o_disp_data  (o_disp_data),
        .o_disp_valid (o_disp_valid),
        .i_disp_ack   (i_disp_ack)
    );

    assign o_mdr     = r_mdr;
    assign o_rdy     = r_rdy;
    assign o_bus_err = r_bus_err;
    assign o_mem_en  = r_mem_en;
    assign o_mem_rw  = r_mem_rw;
    assign o_mem_a   = r_mar;
    assign o_mem_din = r_mdr;

endmodule
`default_nettype wire

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
Memory/IO access controller between the LC-3 control datapath (MAR, MDR, MIO.EN, R.W, R) and the 64K-word synchronous memory block. It owns MAR and MDR, decodes the memory-mapped device registers (KBSR/KBDR/DSR/DDR), and sequences memory requests with a handshake to the RAM's R flag. It returns a single completion strobe to the control FSM.

Parameters:
WAIT_MAX, 15, max cycles spent waiting for mem_r before aborting with bus_err
KBSR_ADDR, 16'hFE00, keyboard status register address
KBDR_ADDR, 16'hFE02, keyboard data register address
DSR_ADDR, 16'hFE04, display status register address
DDR_ADDR, 16'hFE06, display data register address

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bus  in  16  datapath bus value
ld_mar  in  1  load MAR from bus
ld_mdr  in  1  load MDR (source selected by mio_en)
mio_en  in  1  access request; held high by control until rdy
r_w  in  1  1 = write MDR to MAR, 0 = read
mdr  out  16  MDR contents
rdy  out  1  one-cycle access-complete strobe (LC-3 "R")
bus_err  out  1  sticky; set on memory timeout
mem_en  out  1  memory enable to RAM
mem_rw  out  1  memory write select to RAM
mem_a  out  16  memory address (= MAR)
mem_din  out  16  memory write data (= MDR)
mem_dout  in  16  memory read data
mem_r  in  1  memory ready
kb_data  in  8  keyboard character
kb_strobe  in  1  one-cycle new-character pulse
disp_data  out  8  display character (DDR[7:0])
disp_valid  out  1  display character pending
disp_ack  in  1  display consumed character

Behaviour:
- Reset (async, rst_n=0): MAR=0, MDR=0, rdy=0, bus_err=0, mem_en=0, mem_rw=0, KBSR=0, KBDR=0, DSR=16'h8000, DDR=0, disp_valid=0, FSM=IDLE. Reset mid-access aborts with no rdy.
- ld_mar: MAR<=bus at the edge. ld_mdr with mio_en=0: MDR<=bus. ld_mdr with mio_en=1: MDR<=read data at completion (see below). If both ld_mar and an access are active, the access uses the old MAR.
- Decode: is_io = MAR in {KBSR,KBDR,DSR,DDR}; everything else, including other xFExx addresses, goes to memory.
- FSM states: IDLE, MEM, DONE.
- IDLE, mio_en=1, is_io: the IO access executes at that edge; rdy=1 next cycle; go to DONE.
  - IO reads return KBSR={kb_rdy,ie,14'b0}, KBDR={8'b0,kbdr}, DSR={dsr_rdy,15'b0}, DDR; MDR is loaded from the read value.
  - IO writes: KBSR updates only bit14 (IE); DSR is read-only (write ignored); DDR<=MDR, which clears DSR[15] and sets disp_valid.
  - KBDR is read-only.
- IDLE, mio_en=1, memory: mem_en=1 and mem_rw=r_w for exactly one cycle; counter=0; go to MEM.
- MEM: mem_en=0. On mem_r=1: for a read, MDR<=mem_dout; rdy=1 next cycle; go to DONE. Otherwise the counter increments; at counter==WAIT_MAX, set bus_err, pulse rdy (MDR unchanged), go to DONE.
- DONE: rdy=0; wait for mio_en=0, then go to IDLE. This blocks re-issue while control holds mio_en.
- Keyboard:
  - kb_strobe: KBDR<=kb_data and KBSR[15]<=1, overwriting any unread character.
  - A completed read of KBDR clears KBSR[15].
  - If kb_strobe and the KBDR read occur in the same cycle, the strobe wins: new data is loaded and the bit stays set.
- Display:
  - disp_ack while disp_valid: disp_valid<=0 and DSR[15]<=1.
  - A DDR write while disp_valid=1 is still accepted: it overwrites DDR and the flag stays 0/valid stays 1.
  - If disp_ack and a DDR write occur in the same cycle, the write wins.
- rdy is only ever a single-cycle pulse; mem_a and mem_din are continuous copies of MAR and MDR.

Decomposition:
- Package lc3_pkg: the IO address constants, FSM state enum, and a 16-bit word typedef.
- One natural sub-module: lc3_io_regs, holding KBSR/KBDR/DSR/DDR plus the keyboard/display side. The FSM and MAR/MDR stay in the top level.

Test Plan:
- Memory write then read: MAR=16'h3000, MDR=16'hBEEF, write → mem_en one cycle with mem_rw=1; rdy pulses once. Read of 16'h3000 → MDR=16'hBEEF.
- Keyboard: kb_strobe with kb_data=8'h41, then read KBSR → 16'h8000. Read KBDR → 16'h0041, then KBSR reads 16'h0000.
- Display: write DDR=16'h0058 → disp_valid=1, disp_data=8'h58, DSR reads 0. disp_ack → DSR reads 16'h8000, disp_valid=0.
- Timeout: memory request with mem_r held 0 → bus_err=1 and rdy pulse exactly WAIT_MAX+2 cycles after request; MDR unchanged.
- Held mio_en: keep mio_en=1 for 10 cycles after rdy → exactly one mem_en pulse and one rdy.
- Async reset asserted while in MEM → all outputs at reset values immediately. After release, DSR reads 16'h8000 and no rdy appears.
